// File: rtl/serial_frame_tx_pkg.sv
// Shared constants for the serial frame transmitter and the demux controller:
// field widths, line levels and the frame state encoding.
package serial_frame_tx_pkg;

    localparam int PORT_W_DEF = 2;
    localparam int CNT_W_DEF  = 4;

    localparam logic LINE_IDLE_LVL = 1'b1;
    localparam logic START_BIT     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_START = 3'd2,
        ST_PORT  = 3'd3,
        ST_COUNT = 3'd4,
        ST_DATA  = 3'd5
    } frame_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_tx_frame_bit_counter.sv
// Loadable down-counter used to count the bits remaining in a frame field.
// A load wins over counting; counting stops at zero.
module frame_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises a (port, length, payload) request onto one line as
// start bit, port MSB-first, length MSB-first, payload LSB-first.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int   PORT_W   = PORT_W_DEF,
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   DATA_W   = 15,
    parameter logic IDLE_LVL = LINE_IDLE_LVL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              start,
    input  logic [PORT_W-1:0] port_in,
    input  logic [CNT_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ser_out,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = max_int(PORT_W, CNT_W);
    localparam logic [CW-1:0] PORT_LAST = CW'(PORT_W - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_W - 1);

    frame_state_t state, state_n;

    // Shift copies are loaded once on accept and only consumed afterwards,
    // so the request inputs have no influence once a frame is under way.
    logic [PORT_W-1:0] port_sh, port_sh_n;
    logic [CNT_W-1:0]  len_q, len_q_n;
    logic [CNT_W-1:0]  len_sh, len_sh_n;
    logic [DATA_W-1:0] data_sh, data_sh_n;
    logic              ser_q, ser_n;
    logic              done_q, done_n;

    logic              cnt_load;
    logic [CW-1:0]     cnt_val;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;

    frame_bit_counter #(.W(CW)) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (bit_en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            port_sh <= '0;
            len_q   <= '0;
            len_sh  <= '0;
            data_sh <= '0;
            ser_q   <= IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            port_sh <= port_sh_n;
            len_q   <= len_q_n;
            len_sh  <= len_sh_n;
            data_sh <= data_sh_n;
            ser_q   <= ser_n;
            done_q  <= done_n;
        end
    end

    // The line value is decided one edge ahead so every output is a flop.
    always_comb begin
        state_n   = state;
        port_sh_n = port_sh;
        len_q_n   = len_q;
        len_sh_n  = len_sh;
        data_sh_n = data_sh;
        ser_n     = ser_q;
        done_n    = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;

        case (state)
            ST_IDLE: begin
                ser_n = IDLE_LVL;
                if (start) begin
                    state_n   = ST_ARMED;
                    port_sh_n = port_in;
                    len_q_n   = len_in;
                    len_sh_n  = len_in;
                    data_sh_n = data_in;
                end
            end
            ST_ARMED: begin
                if (bit_en) begin
                    state_n = ST_START;
                    ser_n   = START_BIT;
                end
            end
            ST_START: begin
                if (bit_en) begin
                    state_n   = ST_PORT;
                    ser_n     = port_sh[PORT_W-1];
                    port_sh_n = port_sh << 1;
                    cnt_load  = 1'b1;
                    cnt_val   = PORT_LAST;
                end
            end
            ST_PORT: begin
                if (bit_en) begin
                    if (cnt_zero) begin
                        state_n  = ST_COUNT;
                        ser_n    = len_sh[CNT_W-1];
                        len_sh_n = len_sh << 1;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_LAST;
                    end else begin
                        ser_n     = port_sh[PORT_W-1];
                        port_sh_n = port_sh << 1;
                    end
                end
            end
            ST_COUNT: begin
                if (bit_en) begin
                    if (!cnt_zero) begin
                        ser_n    = len_sh[CNT_W-1];
                        len_sh_n = len_sh << 1;
                    end else if (len_q != '0) begin
                        state_n   = ST_DATA;
                        ser_n     = data_sh[0];
                        data_sh_n = data_sh >> 1;
                        cnt_load  = 1'b1;
                        cnt_val   = CW'(len_q) - CW'(1);
                    end else begin
                        state_n = ST_IDLE;
                        ser_n   = IDLE_LVL;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    if (cnt_zero) begin
                        state_n = ST_IDLE;
                        ser_n   = IDLE_LVL;
                        done_n  = 1'b1;
                    end else begin
                        ser_n     = data_sh[0];
                        data_sh_n = data_sh >> 1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                ser_n   = IDLE_LVL;
            end
        endcase
    end

    assign ser_out = ser_q;
    assign done    = done_q;
    assign ready   = (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: table of frames with hand-computed
// line sequences, back-to-back starts, enable gaps, busy guard and mid-frame reset.
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        start;
    logic [1:0]  port_in;
    logic [3:0]  len_in;
    logic [14:0] data_in;
    logic        ser_out;
    logic        ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  len;
        logic [14:0] data;
        logic [31:0] bits;
        int          nbits;
        bit          guard;
        bit          en_on_accept;
        int          gap_max;
    } vec_t;

    vec_t vecs[5];

    serial_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .start   (start),
        .port_in (port_in),
        .len_in  (len_in),
        .data_in (data_in),
        .ser_out (ser_out),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cycle(input logic en, input logic st);
        bit_en = en;
        start  = st;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        start  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        port_in = v.port;
        len_in  = v.len;
        data_in = v.data;
        cycle(v.en_on_accept, 1'b1);
        checkOutput("accept_busy", 32'(busy), 32'd1);
        checkOutput("accept_ready", 32'(ready), 32'd0);
        checkOutput("accept_line_idle", 32'(ser_out), 32'd1);
        checkOutput("accept_no_done", 32'(done), 32'd0);
    endtask

    task automatic sendFrame(input vec_t v);
        logic [31:0] f;
        logic        exp_bit;
        logic        last;
        int          gap;
        bit          st;
        f    = v.bits << (32 - v.nbits);
        last = 1'b1;
        for (int i = 0; i <= v.nbits; i++) begin
            gap = (v.gap_max == 0) ? 0 : int'($urandom_range(v.gap_max, 0));
            for (int g = 0; g < gap; g++) begin
                port_in = 2'($urandom);
                len_in  = 4'($urandom);
                data_in = 15'($urandom);
                cycle(1'b0, 1'b0);
                checkOutput("gap_hold", 32'(ser_out), 32'(last));
                checkOutput("gap_no_done", 32'(done), 32'd0);
            end
            st = v.guard && (i == v.nbits / 2);
            if (st) begin
                port_in = 2'd0;
                len_in  = 4'd1;
                data_in = 15'd0;
            end
            cycle(1'b1, st);
            if (i < v.nbits) begin
                exp_bit = f[31];
                f       = f << 1;
                last    = exp_bit;
                checkOutput("frame_bit", 32'(ser_out), 32'(exp_bit));
                checkOutput("frame_busy", 32'(busy), 32'd1);
                checkOutput("frame_no_done", 32'(done), 32'd0);
            end else begin
                checkOutput("end_line_idle", 32'(ser_out), 32'd1);
                checkOutput("end_done", 32'(done), 32'd1);
                checkOutput("end_ready", 32'(ready), 32'd1);
                checkOutput("end_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{2'd2, 4'd3,  15'b101,   32'b0100011101,              10, 1'b0, 1'b1, 0};
        vecs[1] = '{2'd1, 4'd0,  15'h7FFF,  32'b0010000,                  7, 1'b0, 1'b0, 3};
        vecs[2] = '{2'd3, 4'd15, 15'h00FF,  32'b0111111_11111111_0000000, 22, 1'b1, 1'b1, 7};
        vecs[3] = '{2'd1, 4'd5,  15'h0036,  32'b0_01_0101_01101,          12, 1'b0, 1'b0, 2};
        vecs[4] = '{2'd0, 4'd1,  15'h0001,  32'b0_00_0001_1,               8, 1'b0, 1'b1, 0};

        rst     = 1'b0;
        bit_en  = 1'b0;
        start   = 1'b0;
        port_in = '0;
        len_in  = '0;
        data_in = '0;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        checkOutput("reset_line", 32'(ser_out), 32'd1);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        cycle(1'b0, 1'b0);

        // Each later frame is started in the done cycle of the previous one.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k]);
            sendFrame(vecs[k]);
        end
        cycle(1'b0, 1'b0);
        checkOutput("done_one_clk", 32'(done), 32'd0);
        checkOutput("idle_after_table", 32'(ready), 32'd1);

        // Mid-frame reset while in the payload, with bit_en and start also high.
        applyStimulus(vecs[2]);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        port_in = 2'd1;
        cycle(1'b1, 1'b1);
        rst = 1'b1;
        checkOutput("midrst_line", 32'(ser_out), 32'd1);
        checkOutput("midrst_ready", 32'(ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            checkOutput("postrst_line", 32'(ser_out), 32'd1);
            checkOutput("postrst_ready", 32'(ready), 32'd1);
        end

        applyStimulus(vecs[3]);
        sendFrame(vecs[3]);
        cycle(1'b0, 1'b0);
        checkOutput("recover_done_clear", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Upstream stimulus stage for the serial demux datapath. Takes a parallel request (port, length, payload) and serialises it onto the single SerIn line as one frame, one bit per enable tick:
- start bit 0
- port field
- length field
- payload bits
Its bit_en input is driven by the same one-pulsed clock enable that clocks the demux controller. This lets the board, or a bench, generate legal frames without hand-toggling SerIn.

Parameters:
PORT_W, 2, width of port field (selects p0..p3)
CNT_W, 4, width of length field; max payload length = 2**CNT_W-1
DATA_W, 15, payload register width; must be >= 2**CNT_W-1
IDLE_LVL, 1'b1, line level driven when no frame is in progress

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset; sampled on rising clk; 0 = reset
bit_en  in  1  one-clk-wide bit tick; ser_out may only change on clk edges where bit_en=1 (except reset)
start  in  1  request strobe; accepted only when ready=1
port_in  in  PORT_W  destination port, latched on accept
len_in  in  CNT_W  payload bit count 0..15, latched on accept
data_in  in  DATA_W  payload, latched on accept; bits >= len_in ignored
ser_out  out  1  serial line to demux SerIn
ready  out  1  1 in IDLE (can accept start)
busy  out  1  1 in any state other than IDLE
done  out  1  one-clk pulse when frame completes and line returns to idle

Behaviour:
- All outputs registered; all state changes on rising clk.
- Reset (rst=0, overrides everything incl. mid-frame):
  - state=IDLE, ser_out=IDLE_LVL, ready=1, busy=0, done=0.
  - Latched fields and bit counter cleared.
  - bit_en/start ignored while rst=0.
- States: IDLE, ARMED, START, PORT, COUNT, DATA.
- IDLE:
  - ser_out=IDLE_LVL.
  - start=1 latches port_in/len_in/data_in and moves to ARMED on the next edge, independent of bit_en.
  - start and bit_en together in IDLE: accept only; the start bit is NOT emitted on that edge.
- ARMED: on bit_en -> START, ser_out=0.
- START: on bit_en -> PORT, ser_out=port[PORT_W-1]; bit counter=PORT_W-1.
- PORT: each bit_en emits the next lower port bit, MSB first. After bit 0 has been held one tick, next bit_en -> COUNT, ser_out=len[CNT_W-1].
- COUNT: len bits MSB first. After len bit 0 has been held one tick, next bit_en:
  - len!=0 -> DATA, ser_out=data[0]; counter=len-1.
  - len==0 -> IDLE, ser_out=IDLE_LVL, done=1.
- DATA: payload LSB first, data[0]..data[len-1]; counter decrements per bit_en. After data[len-1] has been held one tick, next bit_en -> IDLE, ser_out=IDLE_LVL, done=1.
- Frame length = 1+PORT_W+CNT_W+len bit periods. Each bit is held exactly from one bit_en edge to the next.
- bit_en gaps of any length simply hold the current bit.
- done is high exactly one clk, on the same edge that enters IDLE; ready=1 in that cycle.
  - start in the done cycle is accepted (back-to-back frames).
  - A back-to-back frame has at least one idle bit period between frames (ARMED waits for the next bit_en).
- start while busy=1 is ignored; latched fields never change mid-frame.
- Input changes while busy have no effect.

Decomposition:
- Shared header/package holds:
  - state encoding localparams (IDLE..DATA)
  - PORT_W/CNT_W defaults
  - IDLE_LVL
  - START_BIT=1'b0
- These same constants are also used by the demux controller.
- One sub-module: frame_bit_counter, a loadable down-counter with zero flag, width max(PORT_W,CNT_W), enabled by bit_en.
- Field muxing and the FSM remain in serial_frame_tx.

Test Plan:
1. Basic frame: port_in=2, len_in=3, data_in=15'b101, then 11 bit_en ticks.
   - ser_out sampled after each tick = 0,1,0,0,0,1,1,1,0,1,1.
   - done pulses once with the 11th tick; busy high from accept to that edge.
2. Zero length: port_in=1, len_in=0.
   - ser_out = 0,0,1,0,0,0,0 then 1.
   - done on the 8th tick; no DATA state visited.
3. Busy guard: start a frame with port=3, len=15; pulse start with port=0, len=1 mid-frame.
   - The transmitted frame is unchanged: 22 bits, port bits 1,1.
   - Exactly one done.
4. Reset mid-frame: assert rst=0 during DATA for one clk.
   - Next cycle: ser_out=1, ready=1, busy=0, done=0.
   - Further bit_en ticks produce no edge on ser_out.
5. Enable gaps and back-to-back:
   - Random 0..7-cycle gaps between bit_en ticks; ser_out must be stable between ticks.
   - start asserted in the done cycle is accepted.
   - The next frame's start bit appears on the 2nd following tick, with the line at 1 for one tick before it.
6. Loopback: drive a full frame into the demux datapath/controller via ser_out -> SerIn, with Clk_EN as bit_en.
   - The selected port output reproduces the payload.
   - serOutvalid asserts for len ticks, and the receiver's Done follows.
